// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard controller bundle: decoder/EX hazard inputs,
// pipeline-register control outputs and performance counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             imem_ready;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output imem_ready, id_ex_mem_read, id_ex_rt,
    output if_id_rs, if_id_rt, id_uses_rt,
    output id_jump, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush,
    input  id_ex_bubble, stall_count, flush_count
  );

  modport slave (
    input  imem_ready, id_ex_mem_read, id_ex_rt,
    input  if_id_rs, if_id_rt, id_uses_rt,
    input  id_jump, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush,
    output id_ex_bubble, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS32 pipeline:
// load-use stalls, branch/jump squash, imem wait states, perf counters.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave hif
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;

  localparam logic [3:0] LU_INIT = 4'(LOAD_LAT - 1);

  state_t           state, state_nx;
  logic [3:0]       lu_cnt, lu_cnt_nx;
  logic             pend_flush, pend_nx;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             lu, br, rdy;
  logic             pc_w, ifid_w, ifid_fl, bub;

  assign br  = hif.ex_branch_taken;
  assign rdy = hif.imem_ready;
  assign lu  = hif.id_ex_mem_read
             && (hif.id_ex_rt != 5'd0)
             && ((hif.id_ex_rt == hif.if_id_rs)
              || (hif.id_uses_rt
               && hif.id_ex_rt == hif.if_id_rt));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      lu_cnt     <= 4'd0;
      pend_flush <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nx;
      lu_cnt     <= lu_cnt_nx;
      pend_flush <= pend_nx;
      if (!pc_w && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (ifid_fl && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    lu_cnt_nx = lu_cnt;
    pend_nx   = pend_flush;
    unique case (state)
      RUN: begin
        if (!br) begin
          if (!rdy) begin
            state_nx = WAIT_MEM;
          end else if (lu && LOAD_LAT > 1) begin
            state_nx  = LU_STALL;
            lu_cnt_nx = LU_INIT;
          end
        end
      end
      LU_STALL: begin
        if (br) begin
          state_nx  = RUN;
          lu_cnt_nx = 4'd0;
        end else begin
          lu_cnt_nx = lu_cnt - 4'd1;
          if (lu_cnt == 4'd1)
            state_nx = RUN;
        end
      end
      WAIT_MEM: begin
        if (br && !rdy) begin
          pend_nx = 1'b1;
        end else if (rdy) begin
          pend_nx  = 1'b0;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Default is the stall set; each branch overrides what differs.
  always_comb begin
    pc_w    = 1'b0;
    ifid_w  = 1'b0;
    ifid_fl = 1'b0;
    bub     = 1'b1;
    if (!reset) begin
      ifid_fl = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (br) begin
            pc_w    = 1'b1;
            ifid_w  = 1'b1;
            ifid_fl = 1'b1;
          end else if (rdy && !lu) begin
            pc_w    = 1'b1;
            ifid_w  = 1'b1;
            ifid_fl = hif.id_jump;
            bub     = 1'b0;
          end
        end
        LU_STALL: begin
          if (br) begin
            pc_w    = 1'b1;
            ifid_w  = 1'b1;
            ifid_fl = 1'b1;
          end
        end
        WAIT_MEM: begin
          if (br && !rdy) begin
            pc_w = 1'b1;
          end else if (rdy) begin
            pc_w    = 1'b1;
            ifid_w  = 1'b1;
            ifid_fl = pend_flush | br;
            bub     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hif.pc_write     = pc_w;
  assign hif.if_id_write  = ifid_w;
  assign hif.if_id_flush  = ifid_fl;
  assign hif.id_ex_bubble = bub;
  assign hif.stall_count  = stall_cnt;
  assign hif.flush_count  = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LAT=3/CNT_W=4
// and LOAD_LAT=1/CNT_W=16) against a cycle-level reference model.
module tb_hazard_ctrl;
  typedef struct packed {
    logic [3:0]  o;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rdy = 1'b1, mr = 1'b0, ur = 1'b0;
  logic       jmp = 1'b0, br = 1'b0;
  logic [4:0] ert = 5'd0, rs = 5'd0, rt = 5'd0;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc_n = 0;
  exp_t q0[$];
  exp_t q1[$];

  int hold[2];
  bit wt[2];
  bit pd[2];
  int sc[2];
  int fc[2];
  int lat[2];
  int cmax[2];

  always #5 clock = ~clock;

  hazard_ctrl_if #(.CNT_W(4))  ia ();
  hazard_ctrl_if #(.CNT_W(16)) ib ();

  assign ia.imem_ready      = rdy;
  assign ia.id_ex_mem_read  = mr;
  assign ia.id_ex_rt        = ert;
  assign ia.if_id_rs        = rs;
  assign ia.if_id_rt        = rt;
  assign ia.id_uses_rt      = ur;
  assign ia.id_jump         = jmp;
  assign ia.ex_branch_taken = br;
  assign ib.imem_ready      = rdy;
  assign ib.id_ex_mem_read  = mr;
  assign ib.id_ex_rt        = ert;
  assign ib.if_id_rs        = rs;
  assign ib.if_id_rt        = rt;
  assign ib.id_uses_rt      = ur;
  assign ib.id_jump         = jmp;
  assign ib.ex_branch_taken = br;

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) ua (
    .clock (clock),
    .reset (reset),
    .hif   (ia.slave)
  );

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) ub (
    .clock (clock),
    .reset (reset),
    .hif   (ib.slave)
  );

  // Outputs as {pc_write, if_id_write, if_id_flush, id_ex_bubble}.
  task automatic model(input int k);
    exp_t e;
    logic lu;
    logic [3:0] o;
    lu = mr && ert != 0 && (ert == rs || (ur && ert == rt));
    if (!reset) begin
      o = 4'b0011;
      hold[k] = 0; wt[k] = 0; pd[k] = 0; sc[k] = 0; fc[k] = 0;
    end else if (hold[k] > 0) begin
      if (br) begin o = 4'b1111; hold[k] = 0; end
      else begin o = 4'b0001; hold[k]--; end
    end else if (wt[k]) begin
      if (br && !rdy) begin o = 4'b1001; pd[k] = 1; end
      else if (rdy) begin
        o = {2'b11, pd[k] | br, 1'b0};
        wt[k] = 0; pd[k] = 0;
      end else o = 4'b0001;
    end else begin
      if (br) o = 4'b1111;
      else if (!rdy) begin o = 4'b0001; wt[k] = 1; end
      else if (lu) begin o = 4'b0001; hold[k] = lat[k] - 1; end
      else if (jmp) o = 4'b1110;
      else o = 4'b1100;
    end
    e.o  = o;
    e.sc = 16'(sc[k]);
    e.fc = 16'(fc[k]);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
    if (reset) begin
      if (!o[3] && sc[k] < cmax[k]) sc[k]++;
      if (o[1] && fc[k] < cmax[k]) fc[k]++;
    end
  endtask

  task automatic cyc(input logic r, input logic y, input logic m,
                     input logic [4:0] e, input logic [4:0] s,
                     input logic [4:0] t, input logic u,
                     input logic j, input logic b);
    @(posedge clock);
    #1;
    reset = r; rdy = y; mr = m; ert = e;
    rs = s; rt = t; ur = u; jmp = j; br = b;
    cyc_n++;
    model(0);
    model(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input int k, input exp_t w, input exp_t g);
    compared++;
    if (g !== w) begin
      mismatched++;
      $display("FAIL outputs inst%0d cyc %0d: got o=%b stall=%0d flush=%0d, want o=%b stall=%0d flush=%0d",
               k, cyc_n, g.o, g.sc, g.fc, w.o, w.sc, w.fc);
    end
  endtask

  always @(negedge clock) begin
    exp_t g;
    if (q0.size() > 0) begin
      g.o  = {ia.pc_write, ia.if_id_write, ia.if_id_flush, ia.id_ex_bubble};
      g.sc = 16'(ia.stall_count);
      g.fc = 16'(ia.flush_count);
      check(0, q0.pop_front(), g);
    end
    if (q1.size() > 0) begin
      g.o  = {ib.pc_write, ib.if_id_write, ib.if_id_flush, ib.id_ex_bubble};
      g.sc = ib.stall_count;
      g.fc = ib.flush_count;
      check(1, q1.pop_front(), g);
    end
  end

  initial begin
    lat[0] = 3; cmax[0] = 15;
    lat[1] = 1; cmax[1] = 65535;
    hold = '{0, 0}; wt = '{0, 0}; pd = '{0, 0};
    sc = '{0, 0}; fc = '{0, 0};
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 1, 1, 8, 8, 0, 0, 0, 0);
    idle(4);
    cyc(1, 1, 1, 9, 1, 9, 1, 0, 0);
    idle(4);
    cyc(1, 1, 1, 0, 0, 0, 1, 0, 0);
    idle(2);
    cyc(1, 1, 1, 8, 8, 0, 0, 0, 1);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    cyc(1, 1, 1, 8, 8, 0, 0, 0, 0);
    idle(1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 20; i++)
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) == 0));
    @(posedge clock);
    @(negedge clock);
    #1;
    compared++;
    if (q0.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d left, want 0/0",
               q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
